// File: rtl/usr_burst.sv
// ---------------------------------------------------------------------------
// usr_burst -- parametrised universal shift register with counted burst mode
//
// A WIDTH-bit register supporting hold, shift right/left, parallel load,
// rotate right/left and arithmetic shift right. A counted burst repeats one
// shift-type op N times on its own, with busy/done status. Used as the
// serial/parallel conversion and bit-alignment stage in datapaths.
//
// Optional feature macro: USR_BURST_ABORT_EN
//   When defined, adds input 'abort' and output 'aborted' so that a running
//   burst can be cancelled. When undefined, bursts always run to completion.
//
// Ports
//   clk           in   1      rising-edge clock
//   rst           in   1      synchronous reset, active-high
//   en            in   1      op enable when idle; 0 = hold
//   mode          in   3      0 hold, 1 shr, 2 shl, 3 load, 4 rotr, 5 rotl,
//                             6 asr, 7 hold
//   p_din         in   WIDTH  parallel data in (load)
//   s_left_din    in   1      serial in to LSB on shl
//   s_right_din   in   1      serial in to MSB on shr
//   burst_start   in   1      start counted burst (idle and en=1 only)
//   burst_len     in   CNT_W  number of ops in the burst
//   p_dout        out  WIDTH  register contents
//   s_left_dout   out  1      p_dout[0]
//   s_right_dout  out  1      p_dout[WIDTH-1]
//   busy          out  1      burst in progress (internal ops pending)
//   done          out  1      one-cycle pulse: burst completed, p_dout final
//   abort         in   1      (USR_BURST_ABORT_EN) cancel running burst
//   aborted       out  1      (USR_BURST_ABORT_EN) one-cycle cancel pulse
// ---------------------------------------------------------------------------
module usr_burst #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] p_din,
  input  logic             s_left_din,
  input  logic             s_right_din,
  input  logic             burst_start,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] p_dout,
  output logic             s_left_dout,
  output logic             s_right_dout,
  output logic             busy,
  output logic             done
`ifdef USR_BURST_ABORT_EN
  ,input  logic            abort
  ,output logic            aborted
`endif
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] data_q;
  logic [2:0]       mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
`ifdef USR_BURST_ABORT_EN
  logic             aborted_q;
`endif

  logic [WIDTH-1:0] idle_data_d;
  logic [WIDTH-1:0] busy_data_d;

  // Next register value for a given op; unknown/hold codes keep the value.
  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] pin,
    input logic             sl,
    input logic             sr
  );
    case (op)
      3'd1:    return {sr, cur[WIDTH-1:1]};
      3'd2:    return {cur[WIDTH-2:0], sl};
      3'd3:    return pin;
      3'd4:    return {cur[0], cur[WIDTH-1:1]};
      3'd5:    return {cur[WIDTH-2:0], cur[WIDTH-1]};
      3'd6:    return {cur[WIDTH-1], cur[WIDTH-1:1]};
      default: return cur;
    endcase
  endfunction

  // Only shift-type ops may be repeated; hold and load degrade to one op.
  function automatic logic is_burst_op(input logic [2:0] op);
    case (op)
      3'd1, 3'd2, 3'd4, 3'd5, 3'd6: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  // Serial inputs are sampled live in both states; only the op code is latched.
  assign idle_data_d = apply_op(mode,   data_q, p_din, s_left_din, s_right_din);
  assign busy_data_d = apply_op(mode_q, data_q, p_din, s_left_din, s_right_din);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      mode_q    <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef USR_BURST_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      done_q    <= 1'b0;
`ifdef USR_BURST_ABORT_EN
      aborted_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (en) begin
            data_q <= idle_data_d;
            if (burst_start && (burst_len != '0) && is_burst_op(mode)) begin
              mode_q <= mode;
              cnt_q  <= burst_len - CNT_W'(1);
              // A one-op burst finishes at its start edge.
              if (burst_len == CNT_W'(1)) begin
                done_q <= 1'b1;
              end else begin
                state_q <= S_BUSY;
                busy_q  <= 1'b1;
              end
            end
          end
        end
        S_BUSY: begin
`ifdef USR_BURST_ABORT_EN
          if (abort) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            aborted_q <= 1'b1;
          end else
`endif
          begin
            data_q <= busy_data_d;
            cnt_q  <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign p_dout       = data_q;
  assign s_left_dout  = data_q[0];
  assign s_right_dout = data_q[WIDTH-1];
  assign busy         = busy_q;
  assign done         = done_q;
`ifdef USR_BURST_ABORT_EN
  assign aborted      = aborted_q;
`endif

endmodule

// File: tb/tb_usr_burst.sv
// ---------------------------------------------------------------------------
// tb_usr_burst -- self-checking bench for usr_burst (WIDTH=8, CNT_W=4)
//
// A behavioural reference model computes the expected outputs for each
// driven cycle; they are queued and compared after the clock edge. Directed
// sequences add fixed expected constants at the key points.
// ---------------------------------------------------------------------------
module tb_usr_burst;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, en, s_left_din, s_right_din, burst_start;
  logic [2:0]    mode;
  logic [W-1:0]  p_din;
  logic [CW-1:0] burst_len;
  logic [W-1:0]  p_dout;
  logic          s_left_dout, s_right_dout, busy, done;
`ifdef USR_BURST_ABORT_EN
  logic          abort, aborted;
`endif

  always #5 clk = ~clk;

  usr_burst #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .mode         (mode),
    .p_din        (p_din),
    .s_left_din   (s_left_din),
    .s_right_din  (s_right_din),
    .burst_start  (burst_start),
    .burst_len    (burst_len),
    .p_dout       (p_dout),
    .s_left_dout  (s_left_dout),
    .s_right_dout (s_right_dout),
    .busy         (busy),
    .done         (done)
`ifdef USR_BURST_ABORT_EN
    ,.abort       (abort)
    ,.aborted     (aborted)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] d;
    logic         b;
    logic         dn;
    logic         ab;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [W-1:0] m_data    = '0;
  logic         m_busy    = 1'b0;
  logic         m_done    = 1'b0;
  logic         m_aborted = 1'b0;
  logic [2:0]   m_mode    = '0;
  int           m_left    = 0;

  function automatic logic [W-1:0] ref_op(input logic [2:0] m, input logic [W-1:0] d,
                                          input logic sl, input logic sr,
                                          input logic [W-1:0] pd);
    case (m)
      3'd1:    return (d >> 1) | {sr, 7'b0};
      3'd2:    return (d << 1) | {7'b0, sl};
      3'd3:    return pd;
      3'd4:    return (d >> 1) | (d << 7);
      3'd5:    return (d << 1) | (d >> 7);
      3'd6:    return W'($signed(d) >>> 1);
      default: return d;
    endcase
  endfunction

  task automatic model_step();
    logic ab_in;
    ab_in = 1'b0;
`ifdef USR_BURST_ABORT_EN
    ab_in = abort;
`endif
    m_done    = 1'b0;
    m_aborted = 1'b0;
    if (rst) begin
      m_data = '0; m_busy = 1'b0; m_mode = '0; m_left = 0;
    end else if (m_busy) begin
      if (ab_in) begin
        m_busy = 1'b0; m_left = 0; m_aborted = 1'b1;
      end else begin
        m_data = ref_op(m_mode, m_data, s_left_din, s_right_din, p_din);
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_busy = 1'b0; m_done = 1'b1;
        end
      end
    end else if (en) begin
      m_data = ref_op(mode, m_data, s_left_din, s_right_din, p_din);
      if (burst_start && burst_len != 0 && mode inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6}) begin
        m_mode = mode;
        m_left = int'(burst_len) - 1;
        if (m_left == 0) m_done = 1'b1;
        else             m_busy = 1'b1;
      end
    end
  endtask

  // Drive one clock with the current inputs and score the outputs after it.
  task automatic cyc(input string tag);
    exp_t e;
    model_step();
    e.d = m_data; e.b = m_busy; e.dn = m_done; e.ab = m_aborted;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 32'(0), 32'(1));
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_dout"},  32'(p_dout),       32'(e.d));
      chk({tag, "_sl"},    32'(s_left_dout),  32'(e.d[0]));
      chk({tag, "_sr"},    32'(s_right_dout), 32'(e.d[W-1]));
      chk({tag, "_busy"},  32'(busy),         32'(e.b));
      chk({tag, "_done"},  32'(done),         32'(e.dn));
`ifdef USR_BURST_ABORT_EN
      chk({tag, "_abrt"},  32'(aborted),      32'(e.ab));
`endif
    end
  endtask

  task automatic load(input logic [W-1:0] v);
    en = 1'b1; mode = 3'd3; p_din = v; burst_start = 1'b0;
    cyc("load");
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = '0; p_din = '0; s_left_din = 1'b0;
    s_right_din = 1'b0; burst_start = 1'b0; burst_len = '0;
`ifdef USR_BURST_ABORT_EN
    abort = 1'b0;
`endif
    #2;
    cyc("rst");
    chk("rst_dout", 32'(p_dout), 32'h00);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    rst = 1'b0;

    // Load and single ops
    load(8'hA5);
    chk("t1_load", 32'(p_dout), 32'hA5);
    chk("t1_sl", 32'(s_left_dout), 32'(1));
    chk("t1_sr", 32'(s_right_dout), 32'(1));
    mode = 3'd5; cyc("t2_rotl"); chk("t2_rotl_k", 32'(p_dout), 32'h4B);
    load(8'hA5);
    mode = 3'd4; cyc("t2_rotr"); chk("t2_rotr_k", 32'(p_dout), 32'hD2);
    load(8'h96);
    mode = 3'd6; cyc("t2_asr");  chk("t2_asr_k", 32'(p_dout), 32'hCB);
    en = 1'b0; mode = 3'd1; cyc("t2_hold"); chk("t2_hold_k", 32'(p_dout), 32'hCB);
    en = 1'b1; s_right_din = 1'b1; cyc("shr"); chk("shr_k", 32'(p_dout), 32'hE5);
    mode = 3'd2; s_left_din = 1'b1; cyc("shl"); chk("shl_k", 32'(p_dout), 32'hCB);
    mode = 3'd0; cyc("m0"); mode = 3'd7; cyc("m7");

    // Burst of 3 shl
    load(8'h81);
    mode = 3'd2; s_left_din = 1'b0; burst_len = 4'd3; burst_start = 1'b1;
    cyc("t3_e1"); chk("t3_e1_k", 32'(p_dout), 32'h02); chk("t3_e1_b", 32'(busy), 32'(1));
    burst_start = 1'b0; mode = 3'd3; p_din = 8'hFF;
    cyc("t3_e2"); chk("t3_e2_k", 32'(p_dout), 32'h04); chk("t3_e2_b", 32'(busy), 32'(1));
    cyc("t3_e3"); chk("t3_e3_k", 32'(p_dout), 32'h08); chk("t3_done", 32'(done), 32'(1));
    chk("t3_e3_b", 32'(busy), 32'(0));
    en = 1'b0; cyc("t3_post"); chk("t3_done_off", 32'(done), 32'(0));

    // Reset mid-burst
    load(8'h81);
    mode = 3'd2; burst_len = 4'd3; burst_start = 1'b1; cyc("t4_e1");
    burst_start = 1'b0; cyc("t4_e2");
    rst = 1'b1; cyc("t4_rst");
    chk("t4_dout", 32'(p_dout), 32'h00); chk("t4_busy", 32'(busy), 32'(0));
    rst = 1'b0; en = 1'b0;
    repeat (3) cyc("t4_after");
    chk("t4_nodone", 32'(done), 32'(0));

    // Degenerate bursts
    load(8'h81);
    mode = 3'd2; burst_len = 4'd0; burst_start = 1'b1; cyc("t5_len0");
    chk("t5_len0_k", 32'(p_dout), 32'h02); chk("t5_len0_b", 32'(busy), 32'(0));
    mode = 3'd3; p_din = 8'h3C; burst_len = 4'd3; cyc("t5_load");
    chk("t5_load_b", 32'(busy), 32'(0)); chk("t5_load_d", 32'(done), 32'(0));
    mode = 3'd7; cyc("t5_hold");
    chk("t5_hold_k", 32'(p_dout), 32'h3C); chk("t5_hold_b", 32'(busy), 32'(0));

    // Back-to-back bursts: second start in the done cycle
    mode = 3'd5; burst_len = 4'd2; burst_start = 1'b1; cyc("t5_b1a");
    mode = 3'd4; cyc("t5_b1b");
    chk("t5_b1_k", 32'(p_dout), 32'hF0); chk("t5_b1_done", 32'(done), 32'(1));
    cyc("t5_b2a");
    chk("t5_b2a_k", 32'(p_dout), 32'h78); chk("t5_b2a_b", 32'(busy), 32'(1));
    burst_start = 1'b0; en = 1'b0; cyc("t5_b2b");
    chk("t5_b2_k", 32'(p_dout), 32'h3C); chk("t5_b2_done", 32'(done), 32'(1));

    // One-op burst and burst longer than the width
    load(8'h01);
    mode = 3'd5; burst_len = 4'd1; burst_start = 1'b1; cyc("len1");
    chk("len1_done", 32'(done), 32'(1)); chk("len1_busy", 32'(busy), 32'(0));
    burst_len = 4'd10; cyc("len10_s");
    burst_start = 1'b0;
    repeat (9) cyc("len10");
    chk("len10_k", 32'(p_dout), 32'h08); chk("len10_done", 32'(done), 32'(1));
    load(8'h80);
    mode = 3'd6; burst_len = 4'd3; burst_start = 1'b1; cyc("asrb");
    burst_start = 1'b0; cyc("asrb"); cyc("asrb");
    chk("asrb_k", 32'(p_dout), 32'hF0); chk("asrb_done", 32'(done), 32'(1));

`ifdef USR_BURST_ABORT_EN
    load(8'h01);
    abort = 1'b1; cyc("t6_idle_abort");
    abort = 1'b0; mode = 3'd5; burst_len = 4'd5; burst_start = 1'b1; cyc("t6_e1");
    burst_start = 1'b0; cyc("t6_e2");
    abort = 1'b1; cyc("t6_e3");
    chk("t6_k", 32'(p_dout), 32'h04); chk("t6_ab", 32'(aborted), 32'(1));
    chk("t6_busy", 32'(busy), 32'(0)); chk("t6_done", 32'(done), 32'(0));
    abort = 1'b0; en = 1'b0; cyc("t6_post");
    chk("t6_ab_off", 32'(aborted), 32'(0));
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 300; i++) begin
      rst         = ($urandom_range(0, 49) == 0);
      en          = ($urandom_range(0, 3) != 0);
      mode        = 3'($urandom_range(0, 7));
      p_din       = 8'($urandom);
      s_left_din  = 1'($urandom);
      s_right_din = 1'($urandom);
      burst_start = ($urandom_range(0, 2) == 0);
      burst_len   = 4'($urandom);
`ifdef USR_BURST_ABORT_EN
      abort       = ($urandom_range(0, 9) == 0);
`endif
      cyc("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
